// File: rtl/graphics_pkg.sv
// rtl/graphics_pkg.sv - shared colour palette types, reset palette and entry decode
//
// Purpose : types and helpers shared by the palette output stage.
// Contents: pal_entry_t   8-bit palette entry (bit0 R, bit1 G, bit2 B, bit3 half)
//           rgb_t         packed {r, g, b} channel triple
//           PAL_ENTRIES   number of colour RAM entries
//           PAL_RESET     palette loaded into both copies at reset
//           pal_to_rgb()  entry -> channel levels
package graphics_pkg;

  typedef logic [7:0] pal_entry_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam int PAL_ENTRIES = 16;

  // Playfield (4-7) and motion-object (12-15) groups both start as
  // black, red, green, white; storage-only entries start at zero.
  localparam pal_entry_t PAL_RESET [PAL_ENTRIES] = '{
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h07,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h07
  };

  function automatic rgb_t pal_to_rgb(input pal_entry_t e, input logic [7:0] half_level);
    rgb_t       res;
    logic [7:0] lvl;
    lvl   = e[3] ? half_level : 8'hFF;
    res.r = e[0] ? lvl : 8'h00;
    res.g = e[1] ? lvl : 8'h00;
    res.b = e[2] ? lvl : 8'h00;
    return res;
  endfunction

endpackage

// File: rtl/palette_ram.sv
// rtl/palette_ram.sv - double-buffered 16-entry colour RAM
//
// Purpose : CPU-side shadow copy plus display-side active copy. A commit
//           copies the whole shadow into active in a single cycle.
// Ports   : clk, rst_l          clock, asynchronous active-low reset
//           wr_en/wr_idx/wr_data shadow write port
//           rd_idx -> rd_data    combinational shadow read (CPU read-back)
//           commit               copy shadow -> active at this edge
//           lk_idx -> lk_data    combinational active lookup (pixel path)
module palette_ram
  import graphics_pkg::*;
(
  input  logic       clk,
  input  logic       rst_l,
  input  logic       wr_en,
  input  logic [3:0] wr_idx,
  input  pal_entry_t wr_data,
  input  logic [3:0] rd_idx,
  output pal_entry_t rd_data,
  input  logic       commit,
  input  logic [3:0] lk_idx,
  output pal_entry_t lk_data
);

  pal_entry_t shadow_q [PAL_ENTRIES];
  pal_entry_t shadow_d [PAL_ENTRIES];
  pal_entry_t active_q [PAL_ENTRIES];
  pal_entry_t active_d [PAL_ENTRIES];

  // Active copies shadow_q, not shadow_d: a write landing in the commit
  // cycle waits for the following commit.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (commit) active_d = shadow_q;
    if (wr_en)  shadow_d[wr_idx] = wr_data;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      shadow_q <= PAL_RESET;
      active_q <= PAL_RESET;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign rd_data = shadow_q[rd_idx];
  assign lk_data = active_q[lk_idx];

endmodule

// File: rtl/palette_output.sv
// rtl/palette_output.sv - palette lookup and VGA output pipeline
//
// Purpose : maps pixel colour codes through the double-buffered colour RAM
//           and drives VGA RGB/sync with matching 2-cycle latency.
// Ports   : clk, rst_l                    clock, asynchronous active-low reset
//           cs_l, we_l, addr, data_in     CPU access (active-low strobes)
//           data_out                      CPU read data from the shadow copy
//           colorCode, motionSel          pixel colour code and source select
//           output_blank                  forces RGB to black
//           hs_in, vs_in, blank_n_in      raw VGA timing
//           VGA_R/G/B, VGA_HS/VS/BLANK_N  pixel-aligned outputs
module palette_output
  import graphics_pkg::*;
#(
  parameter logic [11:0] PAL_BASE   = 12'h140,
  parameter logic [7:0]  HALF_LEVEL = 8'h80
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        cs_l,
  input  logic        we_l,
  input  logic [15:0] addr,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  input  logic [1:0]  colorCode,
  input  logic        motionSel,
  input  logic        output_blank,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic        blank_n_in,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N
);

  logic       pal_sel, wr_en, rd_en, commit;
  pal_entry_t shadow_rd, active_lk;
  logic [3:0] lk_idx;

  logic [7:0] data_out_q, data_out_d;
  logic [1:0] s1_code_q, s1_code_d;
  logic       s1_msel_q, s1_msel_d;
  logic       s1_blank_q, s1_blank_d;
  logic       s1_hs_q, s1_hs_d;
  logic       s1_vs_q, s1_vs_d;     // doubles as the VS edge-detect history
  logic       s1_bn_q, s1_bn_d;
  rgb_t       s2_rgb_q, s2_rgb_d;
  logic       s2_hs_q, s2_hs_d;
  logic       s2_vs_q, s2_vs_d;
  logic       s2_bn_q, s2_bn_d;

  assign pal_sel = ~cs_l && (addr[15:4] == PAL_BASE);
  assign wr_en   = pal_sel & ~we_l;
  assign rd_en   = pal_sel & we_l;
  assign commit  = s1_vs_q & ~vs_in;
  assign lk_idx  = {s1_msel_q, 1'b1, s1_code_q};

  palette_ram u_ram (
    .clk     (clk),
    .rst_l   (rst_l),
    .wr_en   (wr_en),
    .wr_idx  (addr[3:0]),
    .wr_data (data_in),
    .rd_idx  (addr[3:0]),
    .rd_data (shadow_rd),
    .commit  (commit),
    .lk_idx  (lk_idx),
    .lk_data (active_lk)
  );

  always_comb begin
    data_out_d = rd_en ? shadow_rd : data_out_q;
    s1_code_d  = colorCode;
    s1_msel_d  = motionSel;
    s1_blank_d = output_blank;
    s1_hs_d    = hs_in;
    s1_vs_d    = vs_in;
    s1_bn_d    = blank_n_in;
    s2_rgb_d   = s1_blank_q ? '0 : pal_to_rgb(active_lk, HALF_LEVEL);
    s2_hs_d    = s1_hs_q;
    s2_vs_d    = s1_vs_q;
    s2_bn_d    = s1_bn_q;
  end

  // Sync stages reset to the idle (high) level so no false VS edge or
  // sync pulse appears when reset releases.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      data_out_q <= 8'h00;
      s1_code_q  <= 2'd0;
      s1_msel_q  <= 1'b0;
      s1_blank_q <= 1'b0;
      s1_hs_q    <= 1'b1;
      s1_vs_q    <= 1'b1;
      s1_bn_q    <= 1'b0;
      s2_rgb_q   <= '0;
      s2_hs_q    <= 1'b1;
      s2_vs_q    <= 1'b1;
      s2_bn_q    <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      s1_code_q  <= s1_code_d;
      s1_msel_q  <= s1_msel_d;
      s1_blank_q <= s1_blank_d;
      s1_hs_q    <= s1_hs_d;
      s1_vs_q    <= s1_vs_d;
      s1_bn_q    <= s1_bn_d;
      s2_rgb_q   <= s2_rgb_d;
      s2_hs_q    <= s2_hs_d;
      s2_vs_q    <= s2_vs_d;
      s2_bn_q    <= s2_bn_d;
    end
  end

  assign data_out    = data_out_q;
  assign VGA_R       = s2_rgb_q.r;
  assign VGA_G       = s2_rgb_q.g;
  assign VGA_B       = s2_rgb_q.b;
  assign VGA_HS      = s2_hs_q;
  assign VGA_VS      = s2_vs_q;
  assign VGA_BLANK_N = s2_bn_q;

endmodule

// File: tb/tb_palette_output.sv
// tb/tb_palette_output.sv - directed self-checking bench for palette_output
module tb_palette_output;

  logic        clk;
  logic        rst_l;
  logic        cs_l, we_l;
  logic [15:0] addr;
  logic [7:0]  data_in, data_out;
  logic [1:0]  colorCode;
  logic        motionSel, output_blank;
  logic        hs_in, vs_in, blank_n_in;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        VGA_HS, VGA_VS, VGA_BLANK_N;

  int n_chk  = 0;
  int n_pass = 0;

  palette_output dut (
    .clk          (clk),
    .rst_l        (rst_l),
    .cs_l         (cs_l),
    .we_l         (we_l),
    .addr         (addr),
    .data_in      (data_in),
    .data_out     (data_out),
    .colorCode    (colorCode),
    .motionSel    (motionSel),
    .output_blank (output_blank),
    .hs_in        (hs_in),
    .vs_in        (vs_in),
    .blank_n_in   (blank_n_in),
    .VGA_R        (VGA_R),
    .VGA_G        (VGA_G),
    .VGA_B        (VGA_B),
    .VGA_HS       (VGA_HS),
    .VGA_VS       (VGA_VS),
    .VGA_BLANK_N  (VGA_BLANK_N)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] rgb();
    return {8'h00, VGA_R, VGA_G, VGA_B};
  endfunction

  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
    cs_l = 1'b0; we_l = 1'b0; addr = a; data_in = d;
    tick(1);
    cs_l = 1'b1; we_l = 1'b1;
  endtask

  task automatic cpu_rd(input logic [15:0] a);
    cs_l = 1'b0; we_l = 1'b1; addr = a;
    tick(1);
    cs_l = 1'b1;
  endtask

  initial begin
    rst_l = 1'b0; cs_l = 1'b1; we_l = 1'b1; addr = 16'h0000; data_in = 8'h00;
    colorCode = 2'd1; motionSel = 1'b0; output_blank = 1'b0;
    hs_in = 1'b1; vs_in = 1'b1; blank_n_in = 1'b1;
    tick(3);
    chk("rst_rgb", rgb(), 32'h0);
    chk("rst_hs", {31'b0, VGA_HS}, 32'h1);
    chk("rst_vs", {31'b0, VGA_VS}, 32'h1);
    chk("rst_blank_n", {31'b0, VGA_BLANK_N}, 32'h0);
    chk("rst_data_out", {24'b0, data_out}, 32'h0);
    rst_l = 1'b1;

    // Reset palette: entry 5 is red
    tick(2);
    chk("def_red", rgb(), 32'h00FF0000);
    chk("def_blank_n", {31'b0, VGA_BLANK_N}, 32'h1);
    hs_in = 1'b0;
    tick(1);
    chk("hs_lat1", {31'b0, VGA_HS}, 32'h1);
    tick(1);
    chk("hs_lat2", {31'b0, VGA_HS}, 32'h0);
    hs_in = 1'b1;
    tick(2);

    // Double buffering: half-intensity red into entry 5
    cpu_wr(16'h1405, 8'h09);
    cpu_rd(16'h1405);
    chk("db_readback", {24'b0, data_out}, 32'h09);
    tick(2);
    chk("db_pre_commit", rgb(), 32'h00FF0000);
    vs_in = 1'b0;
    tick(1);
    chk("db_commit_edge", rgb(), 32'h00FF0000);
    chk("vs_lat1", {31'b0, VGA_VS}, 32'h1);
    tick(1);
    chk("db_post_commit", rgb(), 32'h00800000);
    chk("vs_lat2", {31'b0, VGA_VS}, 32'h0);
    vs_in = 1'b1;
    tick(3);

    // Write/commit collision on entry 13
    motionSel = 1'b1; colorCode = 2'd1;
    tick(2);
    chk("col_before", rgb(), 32'h00FF0000);
    vs_in = 1'b0;
    cpu_wr(16'h140D, 8'h02);
    tick(2);
    chk("col_same_frame", rgb(), 32'h00FF0000);
    vs_in = 1'b1;
    tick(3);
    chk("col_held", rgb(), 32'h00FF0000);
    cpu_rd(16'h140D);
    chk("col_readback", {24'b0, data_out}, 32'h02);
    vs_in = 1'b0;
    tick(2);
    chk("col_next_commit", rgb(), 32'h0000FF00);
    vs_in = 1'b1;
    tick(2);

    // Blank override on white entry 7
    motionSel = 1'b0; colorCode = 2'd3;
    tick(2);
    chk("white", rgb(), 32'h00FFFFFF);
    output_blank = 1'b1; blank_n_in = 1'b0;
    tick(1);
    chk("blank_lat1_rgb", rgb(), 32'h00FFFFFF);
    chk("blank_lat1_n", {31'b0, VGA_BLANK_N}, 32'h1);
    tick(1);
    chk("blank_rgb", rgb(), 32'h0);
    chk("blank_n", {31'b0, VGA_BLANK_N}, 32'h0);
    output_blank = 1'b0; blank_n_in = 1'b1;
    tick(2);

    // Decode negatives
    cs_l = 1'b1; we_l = 1'b0; addr = 16'h1405; data_in = 8'hFF;
    tick(1);
    cs_l = 1'b0; we_l = 1'b0; addr = 16'h1505; data_in = 8'hFF;
    tick(1);
    we_l = 1'b1;
    tick(1);
    cs_l = 1'b1;
    chk("neg_data_out", {24'b0, data_out}, 32'h02);
    cpu_rd(16'h1405);
    chk("neg_entry5", {24'b0, data_out}, 32'h09);
    colorCode = 2'd1;
    vs_in = 1'b0;
    tick(2);
    chk("neg_active5", rgb(), 32'h00800000);
    vs_in = 1'b1;
    tick(2);

    // Reset mid-operation discards shadow write
    cpu_wr(16'h1406, 8'h04);
    hs_in = 1'b0; blank_n_in = 1'b1;
    tick(2);
    rst_l = 1'b0;
    #1;
    chk("mid_rst_rgb", rgb(), 32'h0);
    chk("mid_rst_hs", {31'b0, VGA_HS}, 32'h1);
    chk("mid_rst_vs", {31'b0, VGA_VS}, 32'h1);
    chk("mid_rst_blank_n", {31'b0, VGA_BLANK_N}, 32'h0);
    chk("mid_rst_data_out", {24'b0, data_out}, 32'h0);
    hs_in = 1'b1;
    tick(2);
    rst_l = 1'b1;
    cpu_rd(16'h1406);
    chk("mid_rst_entry6", {24'b0, data_out}, 32'h02);
    colorCode = 2'd1;
    tick(2);
    chk("mid_rst_red", rgb(), 32'h00FF0000);
    vs_in = 1'b0;
    tick(2);
    chk("mid_rst_commit_red", rgb(), 32'h00FF0000);
    colorCode = 2'd2;
    tick(2);
    chk("mid_rst_commit_green", rgb(), 32'h0000FF00);
    vs_in = 1'b1;
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
